// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read-side handshake between a synchronous FIFO and its consumer
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  modport master (input fifo_empty, input fifo_data, output fifo_rd_en);
  modport slave (output fifo_empty, output fifo_data, input fifo_rd_en);
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a synchronous FIFO and sends them as UART frames
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_en,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic [15:0]           frame_cnt
);
  if (PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_param
    $error("fifo_uart_tx: illegal parameter value");
  end
  localparam int TW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PAR, STOP} state_t;
  state_t        state;
  logic [TW-1:0] tmr;
  logic [2:0]    idx;
  logic          sidx;
  logic [7:0]    sh;
  logic          par;
  logic          bit_end;
  assign bit_end = tmr == TW'(CLKS_PER_BIT - 1);
  assign fifo.fifo_rd_en = rst_n && state == IDLE && tx_en && !fifo.fifo_empty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      frame_cnt <= '0;
      tmr       <= '0;
      idx       <= '0;
      sidx      <= 1'b0;
      sh        <= '0;
      par       <= 1'b0;
    end else begin
      tmr <= (state == IDLE || state == FETCH || bit_end) ? '0 : tmr + 1'b1;
      case (state)
        IDLE:
          if (fifo.fifo_rd_en) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        FETCH: begin
          sh    <= fifo.fifo_data;
          par   <= ^fifo.fifo_data ^ (PARITY == 2);
          idx   <= '0;
          sidx  <= 1'b0;
          tx    <= 1'b0;
          state <= START;
        end
        START:
          if (bit_end) begin
            tx    <= sh[0];
            state <= DATA;
          end
        DATA:
          if (bit_end) begin
            idx   <= idx + 3'd1;
            tx    <= idx == 3'd7 ? (PARITY != 0 ? par : 1'b1) : sh[idx + 3'd1];
            state <= idx == 3'd7 ? (PARITY != 0 ? PAR : STOP) : DATA;
          end
        PAR:
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        STOP:
          if (bit_end) begin
            if (sidx == 1'(STOP_BITS - 1)) begin
              state     <= IDLE;
              busy      <= 1'b0;
              frame_cnt <= frame_cnt + 16'd1;
            end else
              sidx <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: three transmitters (no parity/1 stop, even/1 stop, odd/2 stop) at 4 clocks per bit
module tb_fifo_uart_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en [3];
  logic        rd [3];
  logic        tx [3];
  logic        busy [3];
  logic [15:0] fcnt [3];
  logic [7:0]  mem [3][16];
  int          wp [3];
  logic [15:0] fc [3];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen
    fifo_uart_tx_if f();
    int         rp = 0;
    int         bad = 0;
    logic [7:0] dreg = '0;
    assign f.fifo_empty = (rp == wp[g]);
    assign f.fifo_data  = dreg;
    assign rd[g]        = f.fifo_rd_en;
    always @(posedge clk)
      if (f.fifo_rd_en) begin
        if (f.fifo_empty) bad <= bad + 1;
        else begin
          dreg <= mem[g][rp % 16];
          rp   <= rp + 1;
        end
      end
    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(g), .STOP_BITS(g == 2 ? 2 : 1)) u (
      .clk(clk), .rst_n(rst_n), .tx_en(en[g]), .fifo(f),
      .tx(tx[g]), .busy(busy[g]), .frame_cnt(fcnt[g])
    );
  end

  typedef struct {
    int         g;
    logic [7:0] d;
    logic       ep;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", n, a, e);
    end
  endtask

  function automatic int flen(input int g);
    return g == 0 ? 40 : (g == 1 ? 44 : 48);
  endfunction

  task automatic push(input int g, input logic [7:0] d);
    mem[g][wp[g] % 16] = d;
    wp[g]++;
  endtask

  task automatic rx(input int g, output logic [7:0] d, output logic p, output int w);
    logic s [48];
    logic b [48];
    int   n, unstable, badstop;
    n = flen(g);
    d = '0;
    p = 1'b0;
    w = 0;
    while (!rd[g] && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("rd_en pulse seen", rd[g], 1);
    if (!rd[g]) return;
    @(negedge clk);
    chk("rd_en single cycle", rd[g], 0);
    chk("fetch tx idle", tx[g], 1);
    chk("fetch busy", busy[g], 1);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      s[c] = tx[g];
      b[c] = busy[g];
    end
    unstable = 0;
    for (int c = 0; c < n; c++) if (s[c] !== s[c - c % 4]) unstable++;
    chk("bit held 4 cycles", unstable, 0);
    chk("start bit", s[0], 0);
    for (int i = 0; i < 8; i++) d[i] = s[4 + 4 * i];
    p = s[36];
    badstop = 0;
    for (int c = (g == 0 ? 36 : 40); c < n; c++) if (s[c] !== 1'b1) badstop++;
    chk("stop bits high", badstop, 0);
    chk("busy last frame cycle", b[n - 1], 1);
    @(negedge clk);
    chk("busy after frame", busy[g], 0);
    chk("tx idle after frame", tx[g], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [6];
    logic [7:0] d;
    logic       p;
    int         w, n0, cnt;
    vecs[0] = '{0, 8'h55, 1'b0};
    vecs[1] = '{1, 8'h07, 1'b1};
    vecs[2] = '{2, 8'h07, 1'b0};
    vecs[3] = '{1, 8'h80, 1'b1};
    vecs[4] = '{2, 8'hFF, 1'b1};
    vecs[5] = '{0, 8'h00, 1'b0};
    for (int g = 0; g < 3; g++) begin
      en[g] = 1'b1;
      wp[g] = 0;
      fc[g] = '0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("reset tx", tx[g], 1);
      chk("reset busy", busy[g], 0);
      chk("reset frame_cnt", fcnt[g], 0);
      chk("reset rd_en", rd[g], 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      push(vecs[i].g, vecs[i].d);
      #1;
      rx(vecs[i].g, d, p, w);
      fc[vecs[i].g]++;
      chk("vector data", d, vecs[i].d);
      if (vecs[i].g != 0) chk("vector parity", p, vecs[i].ep);
      chk("vector frame_cnt", fcnt[vecs[i].g], fc[vecs[i].g]);
      repeat (3) @(negedge clk);
    end

    push(0, 8'hA3);
    push(0, 8'h0F);
    push(0, 8'hFF);
    #1;
    n0 = gen[0].rp;
    rx(0, d, p, w);
    chk("b2b byte 0", d, 8'hA3);
    rx(0, d, p, w);
    chk("b2b byte 1", d, 8'h0F);
    chk("b2b gap 1", w, 0);
    rx(0, d, p, w);
    chk("b2b byte 2", d, 8'hFF);
    chk("b2b gap 2", w, 0);
    fc[0] += 16'd3;
    chk("b2b pops", gen[0].rp - n0, 3);
    chk("b2b frame_cnt", fcnt[0], fc[0]);

    push(0, 8'h3C);
    push(0, 8'hC3);
    #1;
    n0 = gen[0].rp;
    fork
      rx(0, d, p, w);
      begin
        repeat (15) @(negedge clk);
        en[0] = 1'b0;
      end
    join
    fc[0]++;
    chk("tx_en drop first byte", d, 8'h3C);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rd[0] || busy[0]) cnt++;
    end
    chk("tx_en low holds idle", cnt, 0);
    chk("tx_en low pops", gen[0].rp - n0, 1);
    en[0] = 1'b1;
    #1;
    rx(0, d, p, w);
    fc[0]++;
    chk("tx_en return second byte", d, 8'hC3);
    chk("tx_en frame_cnt", fcnt[0], fc[0]);

    push(0, 8'h5A);
    #1;
    w = 0;
    while (!rd[0] && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (12) @(negedge clk);
    chk("busy before reset", busy[0], 1);
    rst_n = 1'b0;
    #1;
    chk("async reset tx", tx[0], 1);
    chk("async reset busy", busy[0], 0);
    chk("async reset frame_cnt", fcnt[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int g = 0; g < 3; g++) fc[g] = '0;
    n0 = gen[0].rp;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rd[0] || tx[0] !== 1'b1) cnt++;
    end
    chk("post-reset idle", cnt, 0);
    chk("post-reset no pop", gen[0].rp - n0, 0);

    force gen[0].u.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release gen[0].u.frame_cnt;
    @(negedge clk);
    chk("preload frame_cnt", fcnt[0], 16'hFFFF);
    push(0, 8'h01);
    #1;
    rx(0, d, p, w);
    chk("wrap byte", d, 8'h01);
    chk("frame_cnt wrap", fcnt[0], 16'h0000);

    chk("no pop on empty dut0", gen[0].bad, 0);
    chk("no pop on empty dut1", gen[1].bad, 0);
    chk("no pop on empty dut2", gen[2].bad, 0);
    chk("all consumed dut0", gen[0].rp, wp[0]);
    chk("all consumed dut1", gen[1].rp, wp[1]);
    chk("all consumed dut2", gen[2].rp, wp[2]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
